// File: rtl/accum_ctrl.sv
// ----------------------------------------------------------------------------
// accum_ctrl
//   Sequential control and accumulation stage wrapped around an external
//   WIDTH-bit combinational add/sub unit. A command is taken over a
//   valid/ready handshake. The adder is driven from registers only. Its
//   Sum/Overflow are sampled at the end of a single EXEC cycle. The result is
//   then held on a valid/ready output port until the consumer takes it.
//
// Ports
//   Clk, Rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_op              00=ADD 01=SUB 10=LOAD 11=CLEAR
//   cmd_data            operand (ADD/SUB) or value (LOAD)
//   opA/opB/opSel       to adder: accumulator, latched operand, 1=subtract
//   Sum/Overflow        from adder
//   res_valid/res_ready result handshake
//   res_data/res_ovf    accumulator after the command, its overflow
//   sticky_ovf          OR of ADD/SUB overflows since CLEAR/reset
//   op_count            retired ADD/SUB commands (wraps)
// ----------------------------------------------------------------------------
module accum_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [WIDTH-1:0] opA,
   output logic [WIDTH-1:0] opB,
   output logic             opSel,
   input  logic [WIDTH-1:0] Sum,
   input  logic             Overflow,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_ovf,
   output logic             sticky_ovf,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_OUT  = 2'b10
   } state_e;

   state_e           state;
   op_e              op_q;
   logic [WIDTH-1:0] acc;

   // Accumulator value the current command produces. Only consumed in EXEC.
   // opB doubles as the latched command data for LOAD.
   logic [WIDTH-1:0] acc_nxt;
   logic             ovf_nxt;
   logic             arith;

   always_comb begin
      acc_nxt = acc;
      ovf_nxt = 1'b0;
      arith   = 1'b0;
      case (op_q)
         OP_ADD, OP_SUB: begin
            acc_nxt = Sum;
            ovf_nxt = Overflow;
            arith   = 1'b1;
         end
         OP_LOAD:  acc_nxt = opB;
         OP_CLEAR: acc_nxt = '0;
         default:  acc_nxt = acc;
      endcase
   end

   assign opA = acc;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= S_IDLE;
         op_q       <= OP_ADD;
         acc        <= '0;
         opB        <= '0;
         opSel      <= 1'b0;
         res_data   <= '0;
         res_ovf    <= 1'b0;
         sticky_ovf <= 1'b0;
         op_count   <= '0;
         res_valid  <= 1'b0;
         cmd_ready  <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= op_e'(cmd_op);
                  opB       <= cmd_data;
                  opSel     <= (cmd_op == OP_SUB);
                  cmd_ready <= 1'b0;
                  state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               acc      <= acc_nxt;
               res_data <= acc_nxt;
               res_ovf  <= ovf_nxt;
               if (arith) begin
                  sticky_ovf <= sticky_ovf | Overflow;
                  op_count   <= op_count + 1'b1;
               end else if (op_q == OP_CLEAR) begin
                  sticky_ovf <= 1'b0;
                  op_count   <= '0;
               end
               res_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: begin
               // result stays frozen until the consumer takes it
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accum_ctrl.sv
module tb_accum_ctrl;
   localparam int W  = 4;
   localparam int CW = 2;   // small counter so the wrap is reached quickly

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = 2'b00;
   logic [W-1:0]  cmd_data = '0;
   logic [W-1:0]  opA, opB, Sum;
   logic          opSel, Overflow;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [W-1:0]  res_data;
   logic          res_ovf, sticky_ovf;
   logic [CW-1:0] op_count;

   int vectors = 0;
   int errs    = 0;

   // reference state
   int m_acc = 0, m_sticky = 0, m_cnt = 0;

   accum_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data),
      .opA(opA), .opB(opB), .opSel(opSel),
      .Sum(Sum), .Overflow(Overflow),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_ovf(res_ovf),
      .sticky_ovf(sticky_ovf), .op_count(op_count)
   );

   always #5 Clk = ~Clk;

   // external add/sub unit: signed integer arithmetic, overflow = out of range
   function automatic logic [W:0] adder(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub);
      int sa, sb, r;
      logic [W-1:0] s;
      logic o;
      sa = $signed(a);
      sb = $signed(b);
      r  = sub ? sa - sb : sa + sb;
      o  = (r > (2**(W-1) - 1)) || (r < -(2**(W-1)));
      s  = r[W-1:0];
      return {o, s};
   endfunction

   assign {Overflow, Sum} = adder(opA, opB, opSel);

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: result of a command from the sign rules on unsigned values.
   task automatic model(input int op, input int d, output int r, output int o);
      int a, sa, sd, sr;
      a = m_acc;
      o = 0;
      case (op)
         0, 1: begin
            r  = (op == 0) ? (a + d) % 16 : (a - d + 16) % 16;
            sa = a / 8; sd = d / 8; sr = r / 8;
            if (op == 0) o = (sa == sd) && (sr != sa) ? 1 : 0;
            else         o = (sa != sd) && (sr != sa) ? 1 : 0;
            m_sticky = m_sticky | o;
            m_cnt    = (m_cnt + 1) % (2**CW);
         end
         2: r = d;
         default: begin r = 0; m_sticky = 0; m_cnt = 0; end
      endcase
      m_acc = r;
   endtask

   task automatic do_cmd(input int op, input int d, input int stall);
      int t, r, o;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 20) begin @(negedge Clk); t++; end
      chk("idle_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_data = d[W-1:0];
      @(negedge Clk);                        // accepted; now in EXEC
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 4'($urandom);
      chk("exec_cmd_ready", cmd_ready, 0);
      chk("exec_res_valid", res_valid, 0);
      chk("exec_opA", opA, m_acc);
      chk("exec_opB", opB, d);
      chk("exec_opSel", opSel, (op == 1) ? 1 : 0);
      model(op, d, r, o);
      @(negedge Clk);                        // one EXEC cycle later: OUT
      chk("out_res_valid", res_valid, 1);
      chk("out_res_data", res_data, r);
      chk("out_res_ovf", res_ovf, o);
      chk("out_sticky", sticky_ovf, m_sticky);
      chk("out_count", op_count, m_cnt);
      chk("out_cmd_ready", cmd_ready, 0);
      for (int i = 0; i < stall; i++) begin
         cmd_valid = 1'($urandom);            // must be ignored
         @(negedge Clk);
         chk("hold_res_valid", res_valid, 1);
         chk("hold_res_data", res_data, r);
         chk("hold_res_ovf", res_ovf, o);
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_opB", opB, d);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge Clk);
      res_ready = 1'b0;
      chk("done_res_valid", res_valid, 0);
      chk("done_cmd_ready", cmd_ready, 1);
      chk("done_opA", opA, m_acc);
   endtask

   initial begin
      int r;
      // reset state
      #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_acc", opA, 0);
      chk("rst_count", op_count, 0);
      chk("rst_sticky", sticky_ovf, 0);
      @(negedge Clk); Rst_n = 1'b1;
      @(negedge Clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_res_data", res_data, 0);

      // LOAD 5, ADD 3 -> 1000 with overflow
      do_cmd(2, 5, 0);
      do_cmd(0, 3, 0);
      // LOAD 2, SUB 5 -> 1101, then CLEAR
      do_cmd(2, 2, 0);
      do_cmd(1, 5, 0);
      do_cmd(3, 9, 0);
      // backpressure: SUB 1 from 0 held 4 cycles
      do_cmd(1, 1, 4);
      // counter wrap: 4 x ADD 1 from 0
      do_cmd(3, 0, 0);
      for (int i = 0; i < 4; i++) do_cmd(0, 1, 0);
      // overflow stickiness
      do_cmd(2, 8, 0);
      do_cmd(1, 1, 0);
      do_cmd(0, 0, 1);

      // reset during EXEC of ADD 7
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'd7;
      @(negedge Clk);
      cmd_valid = 1'b0;
      #2 Rst_n = 1'b0;
      #1;
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_opA", opA, 0);
      chk("mid_rst_opB", opB, 0);
      chk("mid_rst_opSel", opSel, 0);
      chk("mid_rst_sticky", sticky_ovf, 0);
      chk("mid_rst_count", op_count, 0);
      chk("mid_rst_res_data", res_data, 0);
      m_acc = 0; m_sticky = 0; m_cnt = 0;
      @(negedge Clk); Rst_n = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         chk("post_rst_res_valid", res_valid, 0);
         chk("post_rst_cmd_ready", cmd_ready, 1);
      end
      do_cmd(2, 6, 0);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 9);
         do_cmd(r < 4 ? 0 : r < 8 ? 1 : r < 9 ? 2 : 3,
                int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
